// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the TX frame controller.
// TX_PREAMBLE_EN adds the PREAMBLE state to the state enum.
package tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAYLOAD,
    ST_TAIL,
    ST_DRAIN
`ifdef TX_PREAMBLE_EN
    , ST_PREAMBLE
`endif
  } tx_state_e;

  localparam int unsigned BITS_PER_SYM  = 4;
  localparam int unsigned CODE_RATE_INV = 2;
  localparam logic [7:0]  PREAMBLE_PAT  = 8'b1010_1100;
  localparam int unsigned PREAMBLE_LEN  = 8;

  // Symbols produced by nbits encoder input bits, rounded up to a whole symbol.
  function automatic logic [31:0] exp_syms(input logic [31:0] nbits);
    return (CODE_RATE_INV * nbits + BITS_PER_SYM - 1) / BITS_PER_SYM;
  endfunction

endpackage

// File: rtl/tx_ce_gen.sv
// Bit-rate enable generator: one bit_ce pulse every DIV clk cycles,
// restarting from zero whenever clear is asserted.
module tx_ce_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_ce
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      bit_ce <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      bit_ce <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt    <= '0;
      bit_ce <= 1'b1;
    end else begin
      cnt    <= cnt + CW'(1);
      bit_ce <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Frame controller for the TX chain: paces the bit-rate stages with bit_ce and
// tracks QAM symbols until the frame drains. TX_PREAMBLE_EN adds a preamble phase.
module tx_frame_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned DIV       = 2,
  parameter int unsigned TAIL_BITS = 3,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             sym_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bit_ce,
  output logic             lfsr_load,
  output logic [6:0]       lfsr_seed,
  output logic             src_zero,
  output logic             enc_valid_in,
  output logic [LEN_W-1:0] sym_cnt
`ifdef TX_PREAMBLE_EN
  ,
  output logic             pre_bit
`endif
);

`ifdef TX_PREAMBLE_EN
  localparam int unsigned PRE_BITS = PREAMBLE_LEN;
`else
  localparam int unsigned PRE_BITS = 0;
`endif
  localparam int unsigned GAP_W = $clog2(DRAIN_MAX);

  tx_state_e        state, state_d;
  logic [LEN_W-1:0] len_q, bit_cnt, bit_cnt_d;
  logic [LEN_W:0]   exp_q;
  logic [GAP_W-1:0] gap;
  logic             accept, reject, complete, timeout, abort_hit, ce_clear;

  tx_ce_gen #(.DIV(DIV)) u_ce_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (ce_clear),
    .bit_ce (bit_ce)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    accept    = 1'b0;
    reject    = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    abort_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            accept    = 1'b1;
            bit_cnt_d = '0;
`ifdef TX_PREAMBLE_EN
            state_d   = ST_PREAMBLE;
`else
            state_d   = ST_LOAD;
`endif
          end else begin
            reject = 1'b1;
          end
        end
      end
`ifdef TX_PREAMBLE_EN
      ST_PREAMBLE: begin
        if (bit_ce) begin
          if (bit_cnt == LEN_W'(PREAMBLE_LEN - 1)) begin
            state_d   = ST_LOAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + LEN_W'(1);
          end
        end
      end
`endif
      ST_LOAD: begin
        if (bit_ce) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (bit_ce) begin
          if (bit_cnt == len_q - LEN_W'(1)) begin
            state_d   = ST_TAIL;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + LEN_W'(1);
          end
        end
      end
      ST_TAIL: begin
        if (bit_ce) begin
          if (bit_cnt == LEN_W'(TAIL_BITS - 1)) begin
            state_d   = ST_DRAIN;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + LEN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // A symbol arriving on the completing cycle is included in the count.
        if (({1'b0, sym_cnt} + (LEN_W+1)'(sym_valid)) >= exp_q) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (!sym_valid && gap >= GAP_W'(DRAIN_MAX - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      abort_hit = 1'b1;
      complete  = 1'b0;
      timeout   = 1'b0;
      state_d   = ST_IDLE;
    end
    // Divider counts from the first cycle after IDLE and stays quiet through DRAIN.
    ce_clear = (state == ST_IDLE) || (state_d == ST_IDLE) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      len_q        <= '0;
      exp_q        <= '0;
      gap          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      lfsr_load    <= 1'b0;
      lfsr_seed    <= '0;
      src_zero     <= 1'b0;
      enc_valid_in <= 1'b0;
      sym_cnt      <= '0;
`ifdef TX_PREAMBLE_EN
      pre_bit      <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      if (accept) begin
        len_q     <= cfg_len;
        lfsr_seed <= cfg_seed;
        exp_q     <= (LEN_W+1)'(exp_syms(32'(cfg_len) + PRE_BITS + TAIL_BITS));
      end
      if (accept)                 sym_cnt <= '0;
      else if (busy && sym_valid) sym_cnt <= sym_cnt + LEN_W'(1);
      // gap holds the cycles elapsed since the last sym_valid (or frame start).
      if (accept || (busy && sym_valid))             gap <= GAP_W'(1);
      else if (busy && gap < GAP_W'(DRAIN_MAX - 1)) gap <= gap + GAP_W'(1);
      busy         <= (state_d != ST_IDLE);
      done         <= complete;
      err          <= reject | abort_hit | timeout;
      lfsr_load    <= (state_d == ST_LOAD);
      src_zero     <= (state_d == ST_TAIL);
`ifdef TX_PREAMBLE_EN
      enc_valid_in <= (state_d inside {ST_PREAMBLE, ST_PAYLOAD, ST_TAIL});
      pre_bit      <= (state_d == ST_PREAMBLE) && PREAMBLE_PAT[3'(PREAMBLE_LEN - 1) - bit_cnt_d[2:0]];
`else
      enc_valid_in <= (state_d inside {ST_PAYLOAD, ST_TAIL});
`endif
    end
  end

endmodule
